avmm_core_dma_engine: RTL and testbench
=======================================

// Module: avmm_core_dma_engine
// PURPOSE
// Parametrised Avalon-MM DMA front end for a byte-serial crypto core (RSA-class). A CSR slave programs
// SRC/DST/NUM_BLK; the master fetches modulus N and exponent E, then streams NUM_BLK message beats from DRAM.
// Each beat is loaded byte-by-byte into the core, processed, unloaded, and written back to DRAM.
// Sits between the PCIe/DDR interconnect and the core, in a single clock domain (no internal clock generator).
// PARAMETERS
// DATA_W     256  master data width; multiple of 8, BYTES=DATA_W/8 a power of two (core operand size)
// ADDR_W     32   master byte-address width
// START_CYC  2    cycles core_start is held high (covers slower core clock)
// PORTS
// clk                 in   1        clock, all logic rising edge
// reset               in   1        asynchronous, active-low
// avs_s0_address      in   3        CSR word address
// avs_s0_read/write   in   1        CSR strobes
// avs_s0_writedata    in   32       CSR write data
// avs_s0_readdata     out  32       CSR read data, combinational, zero latency
// avs_s0_waitrequest  out  1        tied 0
// avm_m0_address      out  ADDR_W   byte address
// avm_m0_read/write   out  1        master strobes, held until waitrequest=0
// avm_m0_waitrequest  in   1        interconnect stall
// avm_m0_readdata     in   DATA_W   read data; avm_m0_readdatavalid in 1 qualifies it
// avm_m0_writedata    out  DATA_W   result beat
// core_we/oe/start    out  1        core load / unload / start
// core_reg_sel        out  2        01 message, 10 N, 11 E, 00 idle
// core_addr           out  log2(BYTES)  byte index
// core_data_i         out  8        byte to core; core_data_o in 8, valid 1 cycle after oe+addr
// core_ready          in   1        core idle/result valid
// irq                 out  1        only when CORE_DMA_IRQ_EN defined
// BEHAVIOUR
// CSR: 0 CTRL{b0 go(W1, self-clr), b1 abort(W1), b2 ie}; 1 STATUS{b0 busy, b1 done W1C, b2 aborted W1C};
//   2 SRC; 3 DST; 4 NUM_BLK; 5 BLK_DONE (RO). Writes to 2..4 and go ignored while busy. Unmapped reads 0.
// Reset: FSM IDLE, all CSRs 0, avm_read/write 0, address/writedata 0, core_* 0, irq 0.
// FSM: IDLE -go-> (NUM_BLK==0 ? DONE : RD_REQ). RD_REQ: read=1 at addr until waitrequest=0 -> RD_WAIT.
//   RD_WAIT: on readdatavalid latch beat -> LOAD. LOAD: BYTES cycles, we=1, addr k, data_i=beat[8k+:8].
//   Beat 0 -> reg_sel 10 (N), beat 1 -> 11 (E), then RD_REQ; beats >=2 -> 01 then START.
//   START: start=1 for START_CYC cycles -> CALC. CALC: wait core_ready=1 (sampled only after START) -> UNLOAD.
//   UNLOAD: oe=1, addr 0..BYTES-1 one per cycle; byte k captured into writedata[8k+:8] one cycle later
//   (BYTES+1 cycles). WR: write=1 at DST+blk*BYTES until waitrequest=0; BLK_DONE++.
//   Then blk<NUM_BLK ? RD_REQ (src+BYTES) : DONE. DONE: done=1, busy=0 -> IDLE (1 cycle).
// Read addresses: SRC, SRC+BYTES, SRC+2*BYTES...; all address arithmetic modulo 2^ADDR_W (wraps silently).
// One outstanding read max; readdatavalid outside RD_WAIT ignored. go clears done/aborted/BLK_DONE.
// Abort: taken at next state boundary; pending avm read/write held until accepted and outstanding
//   readdatavalid absorbed, then IDLE with aborted=1, done=0, core_* deasserted. Abort when idle: no effect.
// Simultaneous go+abort in one write: abort wins, no transfer started.
// Reset mid-operation: immediate return to reset values; no bus completion guaranteed.
// CONFIGURATION
// CORE_DMA_IRQ_EN defined: irq port present, irq = ie & (done | aborted), registered, cleared by W1C.
// Undefined: no irq port; CTRL.ie reads 0; software polls STATUS.
// TESTING
// NUM_BLK=1, SRC=0x0, DST=0x1000, no stalls -> reads 0x0,0x20,0x40; core loads 10,11,01; one write 0x1000; done=1, BLK_DONE=1.
// NUM_BLK=3, waitrequest high 5 cycles per access -> strobes held stable; writes 0x1000,0x1020,0x1040; BLK_DONE=3.
// Core echo model (out=in): beat 0x00..1F bytes -> written beat identical, byte 0 at writedata[7:0].
// NUM_BLK=0, go -> no avm_read ever, done=1 two cycles after go; go while busy -> ignored, SRC unchanged.
// Abort during CALC of block 2 of 4 -> no further writes, aborted=1, done=0, BLK_DONE=1; irq=1 if ie and IRQ_EN.
// SRC=0xFFFFFFE0, NUM_BLK=1 -> reads 0xFFFFFFE0,0x0,0x20 (wrap); reset asserted mid-UNLOAD -> all outputs 0 same cycle.

Source files
------------

// File: rtl/avmm_core_dma_engine.sv
// Avalon-MM DMA front end streaming DRAM beats through a byte-serial crypto core.
// Optional CORE_DMA_IRQ_EN adds a registered irq output and CTRL.ie storage.
module avmm_core_dma_engine #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int START_CYC = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    avs_s0_address,
  input  logic                          avs_s0_read,
  input  logic                          avs_s0_write,
  input  logic [31:0]                   avs_s0_writedata,
  output logic [31:0]                   avs_s0_readdata,
  output logic                          avs_s0_waitrequest,
  output logic [ADDR_W-1:0]             avm_m0_address,
  output logic                          avm_m0_read,
  output logic                          avm_m0_write,
  input  logic                          avm_m0_waitrequest,
  input  logic [DATA_W-1:0]             avm_m0_readdata,
  input  logic                          avm_m0_readdatavalid,
  output logic [DATA_W-1:0]             avm_m0_writedata,
  output logic                          core_we,
  output logic                          core_oe,
  output logic                          core_start,
  output logic [1:0]                    core_reg_sel,
  output logic [$clog2(DATA_W/8)-1:0]   core_addr,
  output logic [7:0]                    core_data_i,
  input  logic [7:0]                    core_data_o,
  input  logic                          core_ready
`ifdef CORE_DMA_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(BYTES);
  localparam int KW    = AW + 1;
  localparam int SW    = $clog2(START_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_LOAD,
    S_START,
    S_CALC,
    S_UNLOAD,
    S_WR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_src;
  logic [31:0]         r_dst;
  logic [31:0]         r_num;
  logic [31:0]         r_blk_done;
  logic                r_done;
  logic                r_aborted;
  logic                r_abort_req;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [1:0]          r_phase;
  logic [KW-1:0]       r_k;
  logic [SW-1:0]       r_scnt;
  logic [DATA_W-1:0]   r_beat;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_ie;
  logic                w_busy;
  logic                w_ctrl_wr;
  logic                w_go;
  logic                w_abort;
  logic                w_take;
  logic [AW-1:0]       w_cap;

`ifdef CORE_DMA_IRQ_EN
  logic r_ie;
  logic r_irq;
  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  assign avs_s0_waitrequest = 1'b0;
  assign avm_m0_writedata   = r_wdata;

  assign w_busy    = !(r_state == S_IDLE || r_state == S_DONE);
  assign w_ctrl_wr = avs_s0_write && (avs_s0_address == 3'd0);
  // abort in the same write as go wins: the go is dropped
  assign w_go      = w_ctrl_wr && avs_s0_writedata[0] &&
                     !avs_s0_writedata[1] && (r_state == S_IDLE);
  assign w_abort   = w_ctrl_wr && avs_s0_writedata[1] && w_busy;
  assign w_take    = r_abort_req && w_busy && (w_next == S_IDLE);
  assign w_cap     = AW'(r_k - KW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    avm_m0_read    = 1'b0;
    avm_m0_write   = 1'b0;
    avm_m0_address = '0;
    core_we        = 1'b0;
    core_oe        = 1'b0;
    core_start     = 1'b0;
    core_reg_sel   = 2'b00;
    core_addr      = '0;
    core_data_i    = 8'd0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = (r_num == 32'd0) ? S_DONE : S_RD_REQ;
      end
      S_RD_REQ: begin
        avm_m0_read    = 1'b1;
        avm_m0_address = r_rd_addr;
        if (!avm_m0_waitrequest) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (avm_m0_readdatavalid)
          w_next = r_abort_req ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        core_we     = 1'b1;
        core_addr   = r_k[AW-1:0];
        core_data_i = r_beat[{r_k[AW-1:0], 3'b000} +: 8];
        unique case (1'b1)
          r_phase == 2'd0: core_reg_sel = 2'b10;
          r_phase == 2'd1: core_reg_sel = 2'b11;
          default:         core_reg_sel = 2'b01;
        endcase
        if (r_k == KW'(BYTES - 1)) begin
          if (r_abort_req)          w_next = S_IDLE;
          else if (r_phase != 2'd2) w_next = S_RD_REQ;
          else                      w_next = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        if (r_scnt == SW'(START_CYC - 1))
          w_next = r_abort_req ? S_IDLE : S_CALC;
      end
      S_CALC: begin
        // no bus traffic is pending here, so abort need not wait for the core
        if (r_abort_req)     w_next = S_IDLE;
        else if (core_ready) w_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        core_oe   = !r_k[AW];
        core_addr = r_k[AW] ? '0 : r_k[AW-1:0];
        if (r_k == KW'(BYTES))
          w_next = r_abort_req ? S_IDLE : S_WR;
      end
      S_WR: begin
        avm_m0_write   = 1'b1;
        avm_m0_address = r_wr_addr;
        if (!avm_m0_waitrequest) begin
          if (r_abort_req)                     w_next = S_IDLE;
          else if (r_blk_done + 32'd1 < r_num) w_next = S_RD_REQ;
          else                                 w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_num       <= '0;
      r_blk_done  <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_abort_req <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_phase     <= '0;
      r_k         <= '0;
      r_scnt      <= '0;
      r_beat      <= '0;
      r_wdata     <= '0;
`ifdef CORE_DMA_IRQ_EN
      r_ie        <= 1'b0;
      r_irq       <= 1'b0;
`endif
    end else begin
      if (avs_s0_write && avs_s0_address == 3'd1) begin
        if (avs_s0_writedata[1]) r_done    <= 1'b0;
        if (avs_s0_writedata[2]) r_aborted <= 1'b0;
      end
      if (avs_s0_write && !w_busy) begin
        case (avs_s0_address)
          3'd2:    r_src <= avs_s0_writedata;
          3'd3:    r_dst <= avs_s0_writedata;
          3'd4:    r_num <= avs_s0_writedata;
          default: ;
        endcase
      end
`ifdef CORE_DMA_IRQ_EN
      if (w_ctrl_wr) r_ie <= avs_s0_writedata[2];
      r_irq <= r_ie & (r_done | r_aborted);
`endif
      if (w_abort) r_abort_req <= 1'b1;
      if (w_go) begin
        r_done     <= 1'b0;
        r_aborted  <= 1'b0;
        r_blk_done <= '0;
        r_rd_addr  <= ADDR_W'(r_src);
        r_wr_addr  <= ADDR_W'(r_dst);
        r_phase    <= '0;
      end

      if (w_next != r_state) r_k <= '0;
      else if (r_state == S_LOAD || r_state == S_UNLOAD)
        r_k <= r_k + KW'(1);

      if (r_state == S_START && w_next == S_START)
        r_scnt <= r_scnt + SW'(1);
      else
        r_scnt <= '0;

      if (r_state == S_RD_REQ && !avm_m0_waitrequest)
        r_rd_addr <= r_rd_addr + ADDR_W'(BYTES);
      if (r_state == S_RD_WAIT && avm_m0_readdatavalid)
        r_beat <= avm_m0_readdata;
      if (r_state == S_LOAD && w_next != S_LOAD && r_phase != 2'd2)
        r_phase <= r_phase + 2'd1;
      // core output lags oe/addr by one cycle, so byte k-1 lands while r_k == k
      if (r_state == S_UNLOAD && r_k != '0)
        r_wdata[{w_cap, 3'b000} +: 8] <= core_data_o;
      if (r_state == S_WR && !avm_m0_waitrequest) begin
        r_wr_addr  <= r_wr_addr + ADDR_W'(BYTES);
        r_blk_done <= r_blk_done + 32'd1;
      end
      if (r_state == S_DONE) r_done <= 1'b1;
      if (r_state == S_IDLE || r_state == S_DONE) r_abort_req <= 1'b0;
      if (w_take) begin
        r_aborted   <= 1'b1;
        r_abort_req <= 1'b0;
      end
    end
  end

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        3'd0:    avs_s0_readdata = {29'd0, w_ie, 2'b00};
        3'd1:    avs_s0_readdata = {29'd0, r_aborted, r_done, w_busy};
        3'd2:    avs_s0_readdata = r_src;
        3'd3:    avs_s0_readdata = r_dst;
        3'd4:    avs_s0_readdata = r_num;
        3'd5:    avs_s0_readdata = r_blk_done;
        default: avs_s0_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_core_dma_engine.sv
// Random jobs against DRAM/core responders; a job-level model predicts
// read/write addresses, load order and result beats (core = msg ^ N ^ E).
`timescale 1ns/1ps
module tb_avmm_core_dma_engine;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    s_addr;
  logic          s_rd, s_wr, s_wait;
  logic [31:0]   s_wd, s_rdata;
  logic [AW-1:0] m_addr;
  logic          m_rd, m_wr, m_wait, m_rdv;
  logic [DW-1:0] m_rdata, m_wdata;
  logic          c_we, c_oe, c_start, c_ready;
  logic [1:0]    c_sel;
  logic [4:0]    c_addr;
  logic [7:0]    c_di, c_do;
  logic          irq_w;

  avmm_core_dma_engine #(.DATA_W(DW), .ADDR_W(AW), .START_CYC(2)) dut (
    .clk(clk), .reset(rst_n),
    .avs_s0_address(s_addr), .avs_s0_read(s_rd), .avs_s0_write(s_wr),
    .avs_s0_writedata(s_wd), .avs_s0_readdata(s_rdata),
    .avs_s0_waitrequest(s_wait),
    .avm_m0_address(m_addr), .avm_m0_read(m_rd), .avm_m0_write(m_wr),
    .avm_m0_waitrequest(m_wait), .avm_m0_readdata(m_rdata),
    .avm_m0_readdatavalid(m_rdv), .avm_m0_writedata(m_wdata),
    .core_we(c_we), .core_oe(c_oe), .core_start(c_start),
    .core_reg_sel(c_sel), .core_addr(c_addr), .core_data_i(c_di),
    .core_data_o(c_do), .core_ready(c_ready)
`ifdef CORE_DMA_IRQ_EN
    , .irq(irq_w)
`endif
  );
`ifndef CORE_DMA_IRQ_EN
  assign irq_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int stall_max = 0;
  bit stall_fixed = 0;
  int core_lat = 0;
  bit tb_ie = 0;
  int viol = 0;
  int sel_bad = 0;

  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0]   q_rd[$];
  logic [31:0]   q_wa[$];
  logic [DW-1:0] q_wd[$];
  logic [1:0]    q_sel[$];

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW / 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // DRAM responder: random/fixed stalls, 1-3 cycle read latency
  initial begin
    int stall_left;
    bit stalling, rd_pend;
    int rd_lat;
    logic [31:0] rd_a, p_addr;
    logic p_rd, p_wr;
    logic [DW-1:0] p_wd;
    stall_left = 0; stalling = 0; rd_pend = 0; rd_lat = 0; rd_a = 0;
    p_addr = 0; p_rd = 0; p_wr = 0; p_wd = 0;
    m_wait = 0; m_rdv = 0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_rdv = 1'b0;
      if (!rst_n) begin
        m_wait = 0; rd_pend = 0; stalling = 0; stall_left = 0;
      end else begin
        if (rd_pend) begin
          if (rd_lat == 0) begin
            m_rdv = 1'b1;
            m_rdata = mem.exists(rd_a) ? mem[rd_a] : '0;
            rd_pend = 0;
          end else rd_lat--;
        end
        if (stalling && (m_rd !== p_rd || m_wr !== p_wr ||
            m_addr !== p_addr || (p_wr && m_wdata !== p_wd)))
          viol++;
        if (m_rd || m_wr) begin
          if (!stalling)
            stall_left = stall_fixed ? stall_max
                                     : $urandom_range(stall_max, 0);
          if (stall_left > 0) begin
            m_wait = 1; stall_left--; stalling = 1;
            p_rd = m_rd; p_wr = m_wr; p_addr = m_addr; p_wd = m_wdata;
          end else begin
            m_wait = 0; stalling = 0;
            if (m_rd) begin
              q_rd.push_back(m_addr);
              rd_pend = 1; rd_a = m_addr; rd_lat = $urandom_range(2, 0);
            end else begin
              q_wa.push_back(m_addr);
              q_wd.push_back(m_wdata);
            end
          end
        end else begin
          m_wait = 1'($urandom_range(1, 0));
          stalling = 0;
        end
      end
    end
  end

  // Core model: byte registers, result = msg ^ N ^ E, data_o one cycle after oe
  initial begin
    logic [DW-1:0] cN, cE, cM, cR;
    int clat;
    bit cbusy, opend;
    logic [4:0] oaddr;
    cN = '0; cE = '0; cM = '0; cR = '0; clat = 0; cbusy = 0;
    opend = 0; oaddr = 0;
    c_ready = 1; c_do = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c_ready = 1; cbusy = 0; opend = 0; c_do = 0;
      end else begin
        if (opend) c_do = cR[8*oaddr +: 8];
        opend = c_oe; oaddr = c_addr;
        if (c_we) begin
          case (c_sel)
            2'b10:   cN[8*c_addr +: 8] = c_di;
            2'b11:   cE[8*c_addr +: 8] = c_di;
            2'b01:   cM[8*c_addr +: 8] = c_di;
            default: sel_bad++;
          endcase
          if (c_addr == 0) q_sel.push_back(c_sel);
        end
        if (c_start) begin
          cbusy = 1; c_ready = 0; cR = cM ^ cN ^ cE;
          clat = (core_lat > 0) ? core_lat : $urandom_range(6, 1);
        end else if (cbusy) begin
          if (clat > 0) clat--;
          else begin c_ready = 1; cbusy = 0; end
        end
      end
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_wd = d; s_wr = 1;
    @(negedge clk);
    s_wr = 0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_rd = 1;
    #1 d = s_rdata;
    s_rd = 0;
  endtask

  task automatic wait_end(input string tg, output logic [31:0] st);
    int n;
    n = 0;
    st = 0;
    while (n < 4000) begin
      csr_rd(3'd1, st);
      if (st[1] | st[2]) break;
      n++;
    end
    chk({tg, "_timeout"}, DW'(n >= 4000), 0);
  endtask

  function automatic logic [31:0] ctrl(input bit go, input bit ab);
    return {29'd0, tb_ie, ab, go};
  endfunction

  task automatic load_mem(input logic [31:0] src, input int nblk);
    for (int i = 0; i < nblk + 2; i++) mem[src + 32'(NB * i)] = rnd_beat();
    q_rd.delete(); q_wa.delete(); q_wd.delete(); q_sel.delete();
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst,
                         input int nblk, input bit poke, input string tg);
    logic [31:0] st, d, ea;
    logic [DW-1:0] key;
    load_mem(src, nblk);
    csr_wr(3'd2, src); csr_wr(3'd3, dst); csr_wr(3'd4, nblk);
    csr_wr(3'd0, ctrl(1, 0));
    if (poke) begin
      repeat (3) @(negedge clk);
      csr_wr(3'd2, 32'hDEAD0000);
      csr_wr(3'd0, ctrl(1, 0));
      csr_rd(3'd2, d);
      chk({tg, "_src_busy"}, d, src);
    end
    wait_end(tg, st);
    chk({tg, "_status"}, st[2:0], 3'b010);
    csr_rd(3'd5, d);
    chk({tg, "_blkdone"}, d, nblk);
    chk({tg, "_nrd"}, q_rd.size(), nblk + 2);
    for (int i = 0; i < nblk + 2; i++) begin
      ea = src + 32'(NB * i);
      chk($sformatf("%s_rd%0d", tg, i),
          (i < q_rd.size()) ? q_rd[i] : ~ea, ea);
      chk($sformatf("%s_sel%0d", tg, i),
          (i < q_sel.size()) ? q_sel[i] : 2'bxx,
          (i == 0) ? 2'b10 : (i == 1) ? 2'b11 : 2'b01);
    end
    chk({tg, "_nwr"}, q_wa.size(), nblk);
    for (int b = 0; b < nblk; b++) begin
      ea = dst + 32'(NB * b);
      key = mem[src + 32'(NB * (b + 2))] ^ mem[src] ^ mem[src + 32'(NB)];
      chk($sformatf("%s_wa%0d", tg, b),
          (b < q_wa.size()) ? q_wa[b] : ~ea, ea);
      chk($sformatf("%s_wd%0d", tg, b),
          (b < q_wd.size()) ? q_wd[b] : ~key, key);
    end
`ifdef CORE_DMA_IRQ_EN
    @(negedge clk);
    chk({tg, "_irq"}, irq_w, tb_ie);
`endif
  endtask

  initial begin
    logic [31:0] d, st;
    int n;
    s_addr = 0; s_rd = 0; s_wr = 0; s_wd = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_out", {m_rd, m_wr, m_addr, c_we, c_oe, c_start, c_sel,
                    c_addr, c_di, irq_w}, 0);
    chk("rst_wdata", m_wdata, 0);
    rst_n = 1;
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), d);
      chk($sformatf("rst_csr%0d", a), d, 0);
    end

    run_job(32'h0, 32'h1000, 1, 0, "basic");

    stall_fixed = 1; stall_max = 5;
    run_job(32'h4000, 32'h1000, 3, 1, "stall");
    stall_fixed = 0; stall_max = 0;

    csr_wr(3'd1, 32'h2);
    csr_rd(3'd1, d);
    chk("done_w1c", d[2:0], 3'b000);

    q_rd.delete();
    csr_wr(3'd4, 0);
    csr_wr(3'd0, ctrl(1, 0));
    csr_rd(3'd1, d);
    chk("nblk0_done", d[2:0], 3'b010);
    repeat (5) @(negedge clk);
    chk("nblk0_nrd", q_rd.size(), 0);
    csr_rd(3'd5, d);
    chk("nblk0_blkdone", d, 0);

    run_job(32'hFFFFFFE0, 32'h2000, 1, 0, "wrap");

    for (int j = 0; j < 6; j++) begin
      stall_max = $urandom_range(3, 0);
      tb_ie = 1'($urandom_range(1, 0));
      run_job($urandom, $urandom, $urandom_range(4, 1), 0,
              $sformatf("rnd%0d", j));
    end
    stall_max = 0;

    tb_ie = 1; core_lat = 40;
    load_mem(32'h8000, 4);
    csr_wr(3'd2, 32'h8000); csr_wr(3'd3, 32'h9000); csr_wr(3'd4, 4);
    csr_wr(3'd0, ctrl(1, 0));
    n = 0;
    while (n < 3000 && !(q_wa.size() == 1 && c_start)) begin
      @(negedge clk); n++;
    end
    while (n < 3000 && c_start) begin
      @(negedge clk); n++;
    end
    chk("abort_reach_calc", DW'(n >= 3000), 0);
    csr_wr(3'd0, ctrl(0, 1));
    wait_end("abort", st);
    chk("abort_status", st[2:0], 3'b100);
    csr_rd(3'd5, d);
    chk("abort_blkdone", d, 1);
    repeat (20) @(negedge clk);
    chk("abort_nwr", q_wa.size(), 1);
    chk("abort_core_idle", {c_we, c_oe, c_start, c_sel, m_rd, m_wr}, 0);
`ifdef CORE_DMA_IRQ_EN
    chk("abort_irq", irq_w, 1);
`endif
    core_lat = 0;
    csr_wr(3'd1, 32'h4);
    csr_rd(3'd1, d);
    chk("abort_w1c", d[2:0], 3'b000);
    chk("abort_irq_clr", irq_w, 0);

    csr_wr(3'd0, ctrl(0, 1));
    csr_rd(3'd1, d);
    chk("idle_abort", d[2:0], 3'b000);

    q_rd.delete();
    csr_wr(3'd4, 2);
    csr_wr(3'd0, ctrl(1, 1));
    repeat (10) @(negedge clk);
    chk("goabort_nrd", q_rd.size(), 0);
    csr_rd(3'd1, d);
    chk("goabort_status", d[2:0], 3'b000);

    load_mem(32'hA000, 1);
    csr_wr(3'd2, 32'hA000); csr_wr(3'd3, 32'hB000); csr_wr(3'd4, 1);
    csr_wr(3'd0, ctrl(1, 0));
    n = 0;
    while (n < 2000 && !c_oe) begin
      @(negedge clk); n++;
    end
    chk("rstmid_reach_unload", DW'(n >= 2000), 0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rstmid_out", {m_rd, m_wr, m_addr, c_we, c_oe, c_start, c_sel,
                       c_addr, c_di, irq_w}, 0);
    chk("rstmid_wdata", m_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    csr_rd(3'd2, d);
    chk("rstmid_src", d, 0);
    csr_rd(3'd1, d);
    chk("rstmid_status", d, 0);

    chk("strobe_stable", viol, 0);
    chk("sel_valid", sel_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1);
  end

endmodule
